// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the cache-to-memory request arbiter.
// State codes, response ID layout and requester port indices.
package mem_port_arbiter_pkg;
   localparam int TID_W  = 2;
   localparam int PORT_W = 2;

   typedef logic [1:0] mem_arb_state_e;
   localparam mem_arb_state_e IDLE    = 2'd0;
   localparam mem_arb_state_e ISSUE   = 2'd1;
   localparam mem_arb_state_e DRAIN   = 2'd2;
   localparam mem_arb_state_e NI_WAIT = 2'd3;

   localparam logic [PORT_W-1:0] PTW    = 2'd0;
   localparam logic [PORT_W-1:0] DCACHE = 2'd1;
   localparam logic [PORT_W-1:0] ICACHE = 2'd2;

   typedef struct packed {
      logic [PORT_W-1:0] port;
      logic [TID_W-1:0]  tid;
   } mem_arb_id_t;
endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Round-robin pick: first set bit of mask at or after ptr.
// Purely combinational; ptr is assumed to be below N.
module rr_arb_pick
   import mem_port_arbiter_pkg::*;
#(
   parameter int N  = 3,
   parameter int PW = 2
) (
   input  logic [N-1:0]  mask,
   input  logic [PW-1:0] ptr,
   output logic          valid,
   output logic [PW-1:0] idx
);
   always_comb begin
      int j;
      valid = 1'b0;
      idx   = '0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr) + k) % N;
         if (!valid && mask[j]) begin
            valid = 1'b1;
            idx   = PW'(j);
         end
      end
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the shared cache-to-memory request channel,
// with outstanding/store caps and non-idempotent access serialization.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int NrPorts              = 3,
   parameter int AddrWidth            = 64,
   parameter int DataWidth            = 64,
   parameter int TidWidth             = 2,
   parameter int MaxOutstanding       = 8,
   parameter int MaxOutstandingStores = 7
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic [NrPorts-1:0]                  req_valid_i,
   output logic [NrPorts-1:0]                  req_ready_o,
   input  logic [NrPorts*AddrWidth-1:0]        req_addr_i,
   input  logic [NrPorts*DataWidth-1:0]        req_wdata_i,
   input  logic [NrPorts-1:0]                  req_we_i,
   input  logic [NrPorts-1:0]                  req_nonidem_i,
   input  logic [NrPorts*TidWidth-1:0]         req_tid_i,
   output logic                                mem_req_valid_o,
   input  logic                                mem_req_ready_i,
   output logic [AddrWidth-1:0]                mem_req_addr_o,
   output logic [DataWidth-1:0]                mem_req_wdata_o,
   output logic                                mem_req_we_o,
   output logic [$clog2(NrPorts)+TidWidth-1:0] mem_req_id_o,
   input  logic                                mem_rsp_valid_i,
   input  logic [$clog2(NrPorts)+TidWidth-1:0] mem_rsp_id_i,
   output logic [NrPorts-1:0]                  mem_rsp_valid_o,
   output logic [TidWidth-1:0]                 mem_rsp_tid_o,
   output logic                                err_o
);
   localparam int PortW = $clog2(NrPorts);
   localparam int IdW   = PortW + TidWidth;
   localparam int NrIds = NrPorts << TidWidth;
   localparam int CntW  = $clog2(MaxOutstanding + 1);

   mem_arb_state_e     state;
   logic [PortW-1:0]   rr_ptr;
   logic               ni_flag;
   logic [CntW-1:0]    total;
   logic [CntW-1:0]    stores;
   logic [NrIds-1:0]   we_tab;

   logic [NrPorts-1:0] elig;
   logic [NrPorts-1:0] ni_elig;
   logic               any_valid;
   logic [PortW-1:0]   any_idx;
   logic               ni_valid;
   logic [PortW-1:0]   ni_idx;
   logic               cap;
   logic               cap_ni;
   logic [PortW-1:0]   cap_idx;
   logic [PortW-1:0]   rsp_port;
   logic               port_ok;
   logic               rsp_ok;
   logic               rsp_st;
   logic               issue;

   always_comb begin
      elig    = '0;
      ni_elig = '0;
      for (int i = 0; i < NrPorts; i++) begin
         elig[i] = req_valid_i[i]
                 && (total < CntW'(MaxOutstanding))
                 && (!req_we_i[i]
                     || stores < CntW'(MaxOutstandingStores));
         ni_elig[i] = elig[i] && req_nonidem_i[i];
      end
   end

   rr_arb_pick #(.N(NrPorts), .PW(PortW)) u_pick_any (
      .mask (elig),
      .ptr  (rr_ptr),
      .valid(any_valid),
      .idx  (any_idx)
   );

   rr_arb_pick #(.N(NrPorts), .PW(PortW)) u_pick_ni (
      .mask (ni_elig),
      .ptr  (rr_ptr),
      .valid(ni_valid),
      .idx  (ni_idx)
   );

   // A nonidem pick in IDLE only captures once nothing is in flight
   always_comb begin
      cap     = 1'b0;
      cap_ni  = 1'b0;
      cap_idx = any_idx;
      unique case (state)
         IDLE: begin
            if (any_valid && !req_nonidem_i[any_idx]) begin
               cap = 1'b1;
            end else if (any_valid && total == '0) begin
               cap    = 1'b1;
               cap_ni = 1'b1;
            end
         end
         DRAIN: begin
            if (total == '0 && ni_valid) begin
               cap     = 1'b1;
               cap_ni  = 1'b1;
               cap_idx = ni_idx;
            end
         end
         default: ;
      endcase
      if (rst_i) cap = 1'b0;
   end

   always_comb begin
      req_ready_o = '0;
      for (int i = 0; i < NrPorts; i++) begin
         req_ready_o[i] = cap && (cap_idx == PortW'(i));
      end
   end

   assign rsp_port = mem_rsp_id_i[IdW-1:TidWidth];
   assign port_ok  = int'(rsp_port) < NrPorts;
   assign rsp_ok   = mem_rsp_valid_i && port_ok && total != '0;
   assign rsp_st   = rsp_ok && we_tab[mem_rsp_id_i] && stores != '0;
   assign issue    = (state == ISSUE) && mem_req_ready_i;

   always_comb begin
      mem_rsp_valid_o = '0;
      for (int i = 0; i < NrPorts; i++) begin
         mem_rsp_valid_o[i] = !rst_i && mem_rsp_valid_i
                            && (rsp_port == PortW'(i));
      end
   end

   assign mem_rsp_tid_o = rst_i ? '0 : mem_rsp_id_i[TidWidth-1:0];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state           <= IDLE;
         rr_ptr          <= '0;
         ni_flag         <= 1'b0;
         total           <= '0;
         stores          <= '0;
         we_tab          <= '0;
         err_o           <= 1'b0;
         mem_req_valid_o <= 1'b0;
         mem_req_addr_o  <= '0;
         mem_req_wdata_o <= '0;
         mem_req_we_o    <= 1'b0;
         mem_req_id_o    <= '0;
      end else begin
         total  <= total + CntW'(issue) - CntW'(rsp_ok);
         stores <= stores + CntW'(issue && mem_req_we_o)
                 - CntW'(rsp_st);
         if (mem_rsp_valid_i && (!port_ok || total == '0)) err_o <= 1'b1;
         if (issue) we_tab[mem_req_id_o] <= mem_req_we_o;
         if (cap) begin
            state           <= ISSUE;
            ni_flag         <= cap_ni;
            mem_req_valid_o <= 1'b1;
            mem_req_addr_o  <= req_addr_i[cap_idx*AddrWidth +: AddrWidth];
            mem_req_wdata_o <= req_wdata_i[cap_idx*DataWidth +: DataWidth];
            mem_req_we_o    <= req_we_i[cap_idx];
            mem_req_id_o    <= {cap_idx,
                                req_tid_i[cap_idx*TidWidth +: TidWidth]};
            rr_ptr <= (int'(cap_idx) == NrPorts - 1) ? '0
                                                     : cap_idx + 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  if (any_valid && req_nonidem_i[any_idx] && total != '0)
                     state <= DRAIN;
               end
               DRAIN: begin
                  if (total == '0 && !ni_valid) state <= IDLE;
               end
               ISSUE: begin
                  if (mem_req_ready_i) begin
                     mem_req_valid_o <= 1'b0;
                     state <= ni_flag ? NI_WAIT : IDLE;
                  end
               end
               NI_WAIT: begin
                  if (total == '0) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: abstract model plus
// directed round-robin, store-cap, nonidem, stall and error scenarios.
module tb_mem_port_arbiter;
   logic          clk_i = 1'b0;
   logic          rst_i;
   logic [2:0]    req_valid_i;
   logic [2:0]    req_ready_o;
   logic [191:0]  req_addr_i;
   logic [191:0]  req_wdata_i;
   logic [2:0]    req_we_i;
   logic [2:0]    req_nonidem_i;
   logic [5:0]    req_tid_i;
   logic          mem_req_valid_o;
   logic          mem_req_ready_i;
   logic [63:0]   mem_req_addr_o;
   logic [63:0]   mem_req_wdata_o;
   logic          mem_req_we_o;
   logic [3:0]    mem_req_id_o;
   logic          mem_rsp_valid_i;
   logic [3:0]    mem_rsp_id_i;
   logic [2:0]    mem_rsp_valid_o;
   logic [1:0]    mem_rsp_tid_o;
   logic          err_o;

   mem_port_arbiter dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_addr_i     (req_addr_i),
      .req_wdata_i    (req_wdata_i),
      .req_we_i       (req_we_i),
      .req_nonidem_i  (req_nonidem_i),
      .req_tid_i      (req_tid_i),
      .mem_req_valid_o(mem_req_valid_o),
      .mem_req_ready_i(mem_req_ready_i),
      .mem_req_addr_o (mem_req_addr_o),
      .mem_req_wdata_o(mem_req_wdata_o),
      .mem_req_we_o   (mem_req_we_o),
      .mem_req_id_o   (mem_req_id_o),
      .mem_rsp_valid_i(mem_rsp_valid_i),
      .mem_rsp_id_i   (mem_rsp_id_i),
      .mem_rsp_valid_o(mem_rsp_valid_o),
      .mem_rsp_tid_o  (mem_rsp_tid_o),
      .err_o          (err_o)
   );

   initial forever #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
      end
   endtask

   // Model state: counts of in-flight work and captured request image
   int          m_total, m_stores, cyc;
   bit          m_err, m_ni, r_seen, cap_pending, hold_flag, exp_ni;
   bit          m_we [16];
   logic [63:0] exp_addr, exp_wdata, h_addr, h_wdata;
   logic        exp_we, h_we;
   logic [3:0]  exp_id, h_id;
   int          grant_log [$];
   int          gstamp [$];

   initial begin
      m_total = 0; m_stores = 0; cyc = 0;
      m_err = 0; m_ni = 0; r_seen = 0;
      cap_pending = 0; hold_flag = 0; exp_ni = 0;
      forever begin
         @(posedge clk_i);
         r_seen = rst_i;
         if (rst_i) begin
            m_total = 0; m_stores = 0; m_err = 0; m_ni = 0;
            cap_pending = 0; hold_flag = 0;
            for (int k = 0; k < 16; k++) m_we[k] = 0;
         end else begin
            int ot;
            int rp;
            ot = m_total;
            rp = int'(mem_rsp_id_i[3:2]);
            if (mem_rsp_valid_i) begin
               if (rp >= 3 || ot == 0) m_err = 1;
               else begin
                  m_total--;
                  if (m_we[mem_rsp_id_i] && m_stores > 0) m_stores--;
               end
            end
            if (mem_req_valid_o && mem_req_ready_i) begin
               m_total++;
               if (mem_req_we_o) m_stores++;
               m_we[mem_req_id_o] = mem_req_we_o;
               if (exp_ni) m_ni = 1;
            end
            if (m_total == 0) m_ni = 0;
            hold_flag = mem_req_valid_o && !mem_req_ready_i;
            h_addr = mem_req_addr_o; h_wdata = mem_req_wdata_o;
            h_we = mem_req_we_o; h_id = mem_req_id_o;
            cap_pending = |req_ready_o;
            for (int i = 0; i < 3; i++) begin
               if (req_ready_o[i]) begin
                  logic [1:0] pi;
                  pi = i[1:0];
                  exp_addr  = req_addr_i[i*64 +: 64];
                  exp_wdata = req_wdata_i[i*64 +: 64];
                  exp_we    = req_we_i[i];
                  exp_id    = {pi, req_tid_i[i*2 +: 2]};
                  exp_ni    = req_nonidem_i[i];
                  grant_log.push_back(i);
                  gstamp.push_back(cyc);
               end
            end
            cyc++;
         end
      end
   end

   initial forever begin
      @(negedge clk_i);
      if (rst_i) begin
         if (r_seen) begin
            chk("rst_ready", req_ready_o, 0);
            chk("rst_mvalid", mem_req_valid_o, 0);
            chk("rst_err", err_o, 0);
            chk("rst_rsp", mem_rsp_valid_o, 0);
         end
      end else begin
         logic [2:0] er;
         er = 3'b000;
         if (mem_rsp_valid_i && mem_rsp_id_i[3:2] < 2'd3)
            er[mem_rsp_id_i[3:2]] = 1'b1;
         chk("err", err_o, m_err);
         chk("rsp_route", mem_rsp_valid_o, er);
         if (mem_rsp_valid_i) chk("rsp_tid", mem_rsp_tid_o, mem_rsp_id_i[1:0]);
         if (cap_pending) begin
            chk("cap_valid", mem_req_valid_o, 1);
            chk("cap_addr", mem_req_addr_o, exp_addr);
            chk("cap_wdata", mem_req_wdata_o, exp_wdata);
            chk("cap_we", mem_req_we_o, exp_we);
            chk("cap_id", mem_req_id_o, exp_id);
         end
         if (hold_flag) begin
            chk("hold_valid", mem_req_valid_o, 1);
            chk("hold_addr", mem_req_addr_o, h_addr);
            chk("hold_wdata", mem_req_wdata_o, h_wdata);
            chk("hold_we", mem_req_we_o, h_we);
            chk("hold_id", mem_req_id_o, h_id);
         end
         chk("rdy_subset", req_ready_o & ~req_valid_i, 0);
         chk("rdy_onehot", $countones(req_ready_o) <= 1, 1);
         for (int i = 0; i < 3; i++) begin
            if (req_ready_o[i]) begin
               chk("cap_total_cap", m_total < 8, 1);
               if (req_we_i[i]) chk("cap_store_cap", m_stores < 7, 1);
               chk("cap_while_busy", mem_req_valid_o, 0);
               if (req_nonidem_i[i]) chk("cap_ni_drain", m_total == 0, 1);
               chk("cap_ni_wait", m_ni && m_total > 0, 0);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_port(input int p, input bit v, input bit we,
                           input bit ni, input logic [1:0] tid,
                           input logic [63:0] a);
      req_valid_i[p]         = v;
      req_we_i[p]            = we;
      req_nonidem_i[p]       = ni;
      req_tid_i[p*2 +: 2]    = tid;
      req_addr_i[p*64 +: 64] = a;
      req_wdata_i[p*64 +: 64] = ~a;
   endtask

   task automatic rsp(input logic [3:0] id);
      mem_rsp_valid_i = 1'b1;
      mem_rsp_id_i    = id;
      tick();
      mem_rsp_valid_i = 1'b0;
   endtask

   task automatic wait_ready(input int p);
      bit ok;
      ok = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk_i);
         if (req_ready_o[p]) begin
            ok = 1;
            break;
         end
      end
      @(posedge clk_i);
      #1;
      chk($sformatf("grant_p%0d", p), ok, 1);
   endtask

   initial begin
      #100000;
      n_fail++;
      $display("FAIL global_timeout t=%0t", $time);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "timeout");
   end

   initial begin
      int g0;
      rst_i = 1'b1;
      req_valid_i = '0; req_addr_i = '0; req_wdata_i = '0;
      req_we_i = '0; req_nonidem_i = '0; req_tid_i = '0;
      mem_req_ready_i = 1'b1;
      mem_rsp_valid_i = 1'b0; mem_rsp_id_i = '0;
      tick();
      req_valid_i = 3'b111;
      mem_rsp_valid_i = 1'b1;
      tick();
      chk("reset_ready", req_ready_o, 0);
      chk("reset_mvalid", mem_req_valid_o, 0);
      chk("reset_rsp", mem_rsp_valid_o, 0);
      chk("reset_err", err_o, 0);
      req_valid_i = '0;
      mem_rsp_valid_i = 1'b0;
      tick();
      rst_i = 1'b0;
      tick();

      // Round-robin over three load requesters
      for (int p = 0; p < 3; p++)
         set_port(p, 1, 0, 0, p[1:0], 64'h1000 * (p + 1));
      g0 = grant_log.size();
      for (int k = 0; k < 40 && grant_log.size() < g0 + 6; k++) tick();
      req_valid_i = '0;
      chk("rr_count", grant_log.size() >= g0 + 6, 1);
      if (grant_log.size() >= g0 + 6) begin
         for (int k = 0; k < 6; k++)
            chk($sformatf("rr_order%0d", k), grant_log[g0+k], k % 3);
         for (int k = 0; k < 5; k++)
            chk($sformatf("rr_gap%0d", k), gstamp[g0+k+1] - gstamp[g0+k], 2);
      end
      tick();
      for (int k = 0; k < 2; k++) begin
         rsp(4'd0); rsp(4'd5); rsp(4'd10);
      end
      chk("rr_drained_err", err_o, 0);

      // Store cap: seven stores in flight stall the eighth
      set_port(1, 1, 1, 0, 2'd1, 64'h2000);
      g0 = grant_log.size();
      for (int k = 0; k < 40 && grant_log.size() < g0 + 7; k++) tick();
      chk("st_count", grant_log.size() >= g0 + 7, 1);
      repeat (6) begin
         tick();
         chk("st_stall", req_ready_o[1], 0);
      end
      set_port(2, 1, 0, 0, 2'd2, 64'h3000);
      wait_ready(2);
      req_valid_i[2] = 1'b0;
      tick();
      repeat (3) begin
         tick();
         chk("st_stall2", req_ready_o[1], 0);
      end
      rsp(4'd5);
      wait_ready(1);
      set_port(1, 0, 0, 0, 2'd0, 64'h0);
      tick();
      repeat (7) rsp(4'd5);
      rsp(4'd10);
      chk("st_drained_err", err_o, 0);
      chk("model_total0", m_total, 0);

      // Nonidem store waits for an older load, then blocks others
      set_port(0, 1, 0, 0, 2'd0, 64'h4000);
      wait_ready(0);
      req_valid_i[0] = 1'b0;
      tick();
      set_port(1, 1, 1, 1, 2'd2, 64'h5000);
      set_port(2, 1, 0, 0, 2'd3, 64'h6000);
      repeat (4) begin
         tick();
         chk("ni_drain_block", req_ready_o, 0);
      end
      rsp(4'd0);
      wait_ready(1);
      set_port(1, 0, 0, 0, 2'd0, 64'h0);
      repeat (4) begin
         tick();
         chk("ni_wait_block", req_ready_o, 0);
      end
      rsp(4'd6);
      wait_ready(2);
      req_valid_i[2] = 1'b0;
      tick();
      rsp(4'd11);

      // Three loads in flight, then a stalled fourth request
      for (int k = 0; k < 3; k++) begin
         set_port(0, 1, 0, 0, 2'd0, 64'h7000 + k);
         wait_ready(0);
         req_valid_i[0] = 1'b0;
         tick();
      end
      mem_req_ready_i = 1'b0;
      set_port(1, 1, 0, 0, 2'd0, 64'hB000);
      set_port(2, 1, 0, 0, 2'd1, 64'hC000);
      wait_ready(1);
      set_port(1, 0, 0, 0, 2'd0, 64'hDEAD);
      repeat (5) begin
         tick();
         chk("stall_nocap", req_ready_o, 0);
         chk("stall_valid", mem_req_valid_o, 1);
         chk("stall_addr", mem_req_addr_o, 64'hB000);
         chk("stall_id", mem_req_id_o, 4'd4);
      end
      // Issue and response on the same edge leave the count at 3
      mem_req_ready_i = 1'b1;
      req_valid_i[2] = 1'b0;
      rsp(4'd0);
      chk("model_total3", m_total, 3);
      rsp(4'd0); rsp(4'd0); rsp(4'd4);
      chk("no_err_after_3", err_o, 0);
      rsp(4'd4);
      chk("err_set", err_o, 1);
      repeat (3) tick();
      chk("err_sticky", err_o, 1);

      // Reset clears err; out-of-range port is dropped
      rst_i = 1'b1;
      tick(); tick();
      chk("err_cleared", err_o, 0);
      rst_i = 1'b0;
      tick();
      set_port(0, 1, 0, 0, 2'd0, 64'h8000);
      wait_ready(0);
      req_valid_i[0] = 1'b0;
      tick();
      mem_rsp_valid_i = 1'b1;
      mem_rsp_id_i = 4'hD;
      #1;
      chk("bad_port_drop", mem_rsp_valid_o, 0);
      tick();
      mem_rsp_valid_i = 1'b0;
      chk("bad_port_err", err_o, 1);

      // In-flight response after a reset is unexpected
      rst_i = 1'b1;
      tick(); tick();
      rst_i = 1'b0;
      tick();
      chk("post_rst_err", err_o, 0);
      rsp(4'd0);
      chk("stale_rsp_err", err_o, 1);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single cache-to-memory request channel between NrPorts requesters: I-cache refill, D-cache miss/writeback and PTW. Arbitration is round-robin. Outstanding requests are tracked, and the arbiter enforces the MaxOutstandingStores limit and strict serialization of non-idempotent accesses. Responses are routed back by ID. It sits between the cache subsystem and the NoC adapter.

Parameters:
NrPorts, 3, number of requesters (0 = PTW, 1 = D-cache, 2 = I-cache)
AddrWidth, 64, request address width
DataWidth, 64, write data width
TidWidth, 2, requester transaction ID width
MaxOutstanding, 8, cap on total in-flight requests
MaxOutstandingStores, 7, cap on in-flight stores

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
req_valid_i  in  NrPorts  per-port request valid
req_ready_o  out  NrPorts  per-port accept
req_addr_i  in  NrPorts*AddrWidth  per-port address
req_wdata_i  in  NrPorts*DataWidth  per-port write data
req_we_i  in  NrPorts  1 = store
req_nonidem_i  in  NrPorts  request targets a non-idempotent region
req_tid_i  in  NrPorts*TidWidth  requester transaction ID
mem_req_valid_o  out  1  downstream request valid
mem_req_ready_i  in  1  downstream accept
mem_req_addr_o  out  AddrWidth  granted address
mem_req_wdata_o  out  DataWidth  granted write data
mem_req_we_o  out  1  granted store flag
mem_req_id_o  out  clog2(NrPorts)+TidWidth  {port index, tid}
mem_rsp_valid_i  in  1  response valid (always accepted)
mem_rsp_id_i  in  clog2(NrPorts)+TidWidth  response ID
mem_rsp_valid_o  out  NrPorts  one-hot routed response valid
mem_rsp_tid_o  out  TidWidth  tid of the routed response
err_o  out  1  sticky: response received with zero outstanding

Behaviour:
- Reset values: all outputs 0; rr pointer = 0; counters = 0; state IDLE; err_o = 0.
- Valid/ready rules: a transfer occurs when valid and ready are both high.
  - req_ready_o[i] is high only in the cycle the arbiter captures port i.
  - mem_req_* are registered and hold stable while valid && !ready.
- Eligibility: port i is eligible when all of the following hold:
  - req_valid_i[i] is high;
  - total < MaxOutstanding;
  - if we: stores < MaxOutstandingStores.
- Pick: the first eligible port at or after rr_ptr. rr_ptr becomes (winner+1) mod NrPorts on capture.
- FSM:
  - IDLE: a pick exists and it is not nonidem → capture into the output register, go ISSUE.
  - IDLE: a pick exists, it is nonidem and total > 0 → go DRAIN. Do not capture.
  - IDLE: a pick exists, it is nonidem and total == 0 → capture, go ISSUE with ni_flag set.
  - DRAIN: no captures. When total == 0, capture the highest-priority nonidem eligible port (same rr order), go ISSUE with ni_flag set.
  - ISSUE: on mem_req_ready_i, increment total (and stores if we). If ni_flag is set go NI_WAIT, else IDLE. Issue latency is 1 cycle from capture to mem_req_valid_o.
  - NI_WAIT: no captures. When total returns to 0, go IDLE.
- Responses, combinational routing:
  - mem_rsp_valid_o[id.port] = mem_rsp_valid_i; mem_rsp_tid_o = id.tid.
  - Decrement total. Decrement stores if the response belongs to a store; this is tracked by a per-ID we bit (NrPorts × 2^TidWidth entries) set at issue.
- Simultaneous issue and response in one cycle: net counter change = +issue − response. A counter never wraps.
- Response while total == 0: set err_o, leave counters unchanged, still route the response.
- Port index ≥ NrPorts in a response ID: drop it and set err_o.
- Reset mid-operation: all state is lost; in-flight responses after reset are treated as unexpected.
- Port behaviour: a port may deassert req_valid_i before it is granted. The arbiter has no starvation beyond NrPorts−1 grants per port, unless blocked by the caps.

Decomposition:
- Shared package (cva6 config package area): mem_arb_state_e {IDLE, ISSUE, DRAIN, NI_WAIT}, a typedef for the ID struct {port, tid}, and port index constants PTW/DCACHE/ICACHE.
- One natural sub-module: rr_arb_pick (combinational rotate/priority pick over an eligible mask plus a pointer).

Test Plan:
- Ports 0, 1, 2 all valid with loads, mem_req_ready_i = 1 → grants in order 0, 1, 2, 0…, one capture every 2 cycles, IDs carry the correct port index.
- Port 1 issues 7 stores with no responses → the 8th store is stalled with req_ready_o[1] = 0; port 2 loads continue. After one store response, the 8th store issues.
- Port 0 load outstanding, then port 1 nonidem store → DRAIN until the load response, then issue. Port 2 is blocked until the store response arrives.
- mem_req_ready_i held low for 5 cycles → mem_req_addr_o, mem_req_wdata_o and mem_req_id_o stay stable, and no new capture occurs.
- Issue handshake and response in the same cycle with total = 3 → total stays 3.
- Response arrives with total = 0 → err_o = 1 and stays 1 until rst_i.
